// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master among NUM_REQ local requesters.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort stuck transfers with ack_error.
module spi_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_rd_we,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    input  logic [NUM_REQ*16-1:0]            req_divider,
    input  logic [NUM_REQ-1:0]               req_cpha,
    input  logic [NUM_REQ-1:0]               req_cpol,
    output logic [NUM_REQ-1:0]               ack,
    output logic [DATA_WIDTH-1:0]            ack_rdata,
    output logic                             ack_error,
    output logic                             arb_busy,
    output logic                             spi_enable,
    output logic                             spi_rd_we,
    output logic [ADDRESS_WIDTH-1:0]         spi_address,
    output logic [DATA_WIDTH-1:0]            spi_data,
    output logic [15:0]                      spi_divider,
    output logic                             spi_clock_phase,
    output logic                             spi_clock_polarity,
    input  logic                             spi_busy,
    input  logic [DATA_WIDTH-1:0]            spi_data_read,
    input  logic                             spi_data_read_valid
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE
    } state_t;

    state_t                 state, state_nx;
    logic [IW-1:0]          ptr, idx, win;
    logic                   win_vld;
    logic [DATA_WIDTH-1:0]  rdata_cap;
    logic                   tmo_hit;
    logic                   in_wait;

    assign in_wait = (state == WAIT_BUSY) || (state == WAIT_DONE);

    // Scan from the highest offset down so the nearest set bit at/after ptr wins.
    always_comb begin
        logic [IW:0] j;
        win     = '0;
        win_vld = 1'b0;
        j       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = {1'b0, ptr} + (IW+1)'(k);
            if (j >= (IW+1)'(NUM_REQ))
                j = j - (IW+1)'(NUM_REQ);
            if (req[j[IW-1:0]]) begin
                win     = j[IW-1:0];
                win_vld = 1'b1;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clock) begin
        if (reset || state == ISSUE)
            tmo_cnt <= '0;
        else if (in_wait)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = in_wait && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (win_vld) state_nx = ISSUE;
            ISSUE:     state_nx = WAIT_BUSY;
            WAIT_BUSY: if (tmo_hit) state_nx = COMPLETE;
                       else if (spi_busy) state_nx = WAIT_DONE;
            WAIT_DONE: if (tmo_hit || !spi_busy) state_nx = COMPLETE;
            COMPLETE:  state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            ptr                <= '0;
            idx                <= '0;
            rdata_cap          <= '0;
            ack                <= '0;
            ack_rdata          <= '0;
            ack_error          <= 1'b0;
            arb_busy           <= 1'b0;
            spi_enable         <= 1'b0;
            spi_rd_we          <= 1'b0;
            spi_address        <= '0;
            spi_data           <= '0;
            spi_divider        <= '0;
            spi_clock_phase    <= 1'b0;
            spi_clock_polarity <= 1'b0;
        end else begin
            state      <= state_nx;
            arb_busy   <= (state_nx != IDLE);
            spi_enable <= (state == ISSUE);
            ack        <= '0;

            case (state)
                IDLE: if (win_vld) begin
                    idx                <= win;
                    rdata_cap          <= '0;
                    spi_rd_we          <= req_rd_we[win];
                    spi_address        <= req_address[win*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    spi_data           <= req_data[win*DATA_WIDTH +: DATA_WIDTH];
                    spi_divider        <= req_divider[win*16 +: 16];
                    spi_clock_phase    <= req_cpha[win];
                    spi_clock_polarity <= req_cpol[win];
                end
                WAIT_DONE: if (spi_data_read_valid && !spi_rd_we)
                    rdata_cap <= spi_data_read;
                COMPLETE:
                    ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
                default: ;
            endcase

            // Ack is raised on entry to COMPLETE so it is visible for exactly that cycle;
            // a valid arriving with busy's fall is forwarded directly.
            if (in_wait && state_nx == COMPLETE) begin
                ack[idx]  <= 1'b1;
                ack_error <= tmo_hit;
                if (tmo_hit || spi_rd_we)
                    ack_rdata <= '0;
                else if (spi_data_read_valid)
                    ack_rdata <= spi_data_read;
                else
                    ack_rdata <= rdata_cap;
            end
        end
    end

endmodule
